// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the
// address decoder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped transfers
// plus a saturating count of them.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        hready,
  input  logic        start,
  input  logic        active,
  output logic        ds_ready,
  output logic        ds_resp,
  output logic [15:0] err_count
);

  ds_state_e   state_q;
  logic        ready_q;
  logic        resp_q;
  logic [15:0] err_count_q;
  logic        enter_err;

  // ERR2 already drives HREADY=1, so a new unmapped address phase chains straight into ERR1.
  assign enter_err = hready && start && (state_q == DS_OK || state_q == DS_ERR2);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= DS_OK;
      ready_q     <= 1'b1;
      resp_q      <= RESP_OKAY;
      err_count_q <= '0;
    end else if (enter_err) begin
      state_q <= DS_ERR1;
      ready_q <= 1'b0;
      resp_q  <= RESP_ERROR;
      if (err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end else begin
      case (state_q)
        DS_ERR1: begin
          if (active) begin
            state_q <= DS_ERR2;
            ready_q <= 1'b1;
            resp_q  <= RESP_ERROR;
          end else begin
            state_q <= DS_OK;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
          end
        end
        default: begin
          state_q <= DS_OK;
          ready_q <= 1'b1;
          resp_q  <= RESP_OKAY;
        end
      endcase
    end
  end

  assign ds_ready  = ready_q;
  assign ds_resp   = resp_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/ahb_slave_decoder.sv
// AHB-Lite address decoder for NUM_SLAVES equal regions with a registered
// data-phase response mux and a built-in default (error) slave.
module ahb_slave_decoder
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] REGION_SIZE = 32'h0000_1400
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic [NUM_SLAVES-1:0]    HSEL,
  input  logic [NUM_SLAVES*32-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]    HRESP_S,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [15:0]              err_count
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_SLAVES-1:0] hsel_dec;
  logic [IDX_W-1:0]      dec_idx;
  logic                  mapped;
  logic                  xfer;
  logic                  start;
  logic [IDX_W-1:0]      dsel_idx_q;
  logic                  dsel_def_q;
  logic                  ds_ready;
  logic                  ds_resp;

  // Region bounds are 33 bits wide so the top region's end cannot wrap to zero.
  always_comb begin
    logic [32:0] addr_ext;
    logic [32:0] lo;
    logic [32:0] hi;
    addr_ext = {1'b0, HADDR};
    lo       = '0;
    hi       = '0;
    hsel_dec = '0;
    dec_idx  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      lo = {1'b0, BASE_ADDR} + 33'(i) * {1'b0, REGION_SIZE};
      hi = lo + {1'b0, REGION_SIZE};
      if (addr_ext >= lo && addr_ext < hi) begin
        hsel_dec[i] = 1'b1;
        dec_idx     = IDX_W'(i);
      end
    end
  end

  assign HSEL   = hsel_dec;
  assign mapped = |hsel_dec;
  assign xfer   = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign start  = !mapped && xfer;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_idx_q <= '0;
      dsel_def_q <= 1'b1;
    end else if (HREADY) begin
      dsel_idx_q <= dec_idx;
      dsel_def_q <= !mapped;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .hready    (HREADY),
    .start     (start),
    .active    (dsel_def_q),
    .ds_ready  (ds_ready),
    .ds_resp   (ds_resp),
    .err_count (err_count)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = ds_ready;
    HRESP  = ds_resp;
    if (!dsel_def_q) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dsel_idx_q == IDX_W'(i)) begin
          HRDATA = HRDATA_S[32*i +: 32];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_decoder.sv
// Directed self-checking bench for ahb_slave_decoder with two slaves.
module tb_ahb_slave_decoder;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [1:0]  HSEL;
  logic [63:0] HRDATA_S;
  logic [1:0]  HREADYOUT_S;
  logic [1:0]  HRESP_S;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  ahb_slave_decoder #(
    .NUM_SLAVES  (2),
    .BASE_ADDR   (32'h0000_0000),
    .REGION_SIZE (32'h0000_1400)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .err_count   (err_count)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic rdy, input logic rsp);
    #1;
    chk({tag, ".hready"}, {31'd0, HREADY}, {31'd0, rdy});
    chk({tag, ".hresp"}, {31'd0, HRESP}, {31'd0, rsp});
  endtask

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  initial begin
    HRESET      = 1'b1;
    HADDR       = 32'h0;
    HTRANS      = IDLE;
    HRDATA_S    = '0;
    HREADYOUT_S = 2'b11;
    HRESP_S     = 2'b00;
    #1;
    chk("reset_hsel", {30'd0, HSEL}, 32'h1);
    tick();
    tick();

    // Reset state
    HRESET = 1'b0;
    #1;
    chk("rst_hready", {31'd0, HREADY}, 32'h1);
    chk("rst_hresp", {31'd0, HRESP}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_errcnt", {16'd0, err_count}, 32'h0);

    // Mapped read from slave 1
    HADDR = 32'h0000_1400; HTRANS = NONSEQ;
    #1 chk("rd1_hsel", {30'd0, HSEL}, 32'h2);
    tick();
    HADDR = 32'h0; HTRANS = IDLE;
    HRDATA_S = {32'hDEAD_BEEF, 32'h0};
    #1;
    chk("rd1_hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("rd1_hready", {31'd0, HREADY}, 32'h1);
    tick();

    // Slave 0 wait states with an unmapped address pending
    HADDR = 32'h0000_0010; HTRANS = NONSEQ;
    tick();
    HADDR = 32'h0000_2800; HTRANS = NONSEQ;
    HREADYOUT_S = 2'b10;
    for (int i = 0; i < 3; i++) begin
      chk_rsp("ws_wait", 1'b0, 1'b0);
      tick();
    end
    chk("ws_errcnt", {16'd0, err_count}, 32'h0);
    HREADYOUT_S = 2'b11;
    chk_rsp("ws_done", 1'b1, 1'b0);
    tick();
    HADDR = 32'h0; HTRANS = IDLE;
    chk_rsp("ws_err1", 1'b0, 1'b1);
    chk("ws_errcnt1", {16'd0, err_count}, 32'h1);
    tick();
    chk_rsp("ws_err2", 1'b1, 1'b1);
    tick();
    chk_rsp("ws_ok", 1'b1, 1'b0);
    tick();

    // Isolated unmapped NONSEQ
    HADDR = 32'h0000_2800; HTRANS = NONSEQ;
    #1 chk("um_hsel", {30'd0, HSEL}, 32'h0);
    tick();
    HADDR = 32'h0; HTRANS = IDLE;
    chk_rsp("um_err1", 1'b0, 1'b1);
    chk("um_hrdata", HRDATA, 32'h0);
    tick();
    chk_rsp("um_err2", 1'b1, 1'b1);
    tick();
    chk_rsp("um_ok", 1'b1, 1'b0);
    chk("um_errcnt", {16'd0, err_count}, 32'h2);
    tick();

    // Unmapped IDLE gets zero-wait OKAY
    HADDR = 32'h0000_2800; HTRANS = IDLE;
    tick();
    HADDR = 32'h0;
    chk_rsp("idle_ok", 1'b1, 1'b0);
    chk("idle_errcnt", {16'd0, err_count}, 32'h2);
    tick();

    // Three back-to-back unmapped NONSEQ
    HADDR = 32'hFFFF_FFFC; HTRANS = NONSEQ;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        HADDR = 32'h0; HTRANS = IDLE;
      end
      chk_rsp("b2b_err1", 1'b0, 1'b1);
      tick();
      chk_rsp("b2b_err2", 1'b1, 1'b1);
      tick();
    end
    chk_rsp("b2b_ok", 1'b1, 1'b0);
    chk("b2b_errcnt", {16'd0, err_count}, 32'h5);

    // Region boundaries and slave 0 data / slave 1 error passthrough
    HADDR = 32'h0000_13FC; HTRANS = NONSEQ;
    #1 chk("bnd_13fc", {30'd0, HSEL}, 32'h1);
    tick();
    HADDR = 32'h0000_27FC;
    HRDATA_S = {32'h0, 32'h1234_5678};
    #1;
    chk("bnd_s0_data", HRDATA, 32'h1234_5678);
    chk("bnd_27fc", {30'd0, HSEL}, 32'h2);
    tick();
    HADDR = 32'h0; HTRANS = IDLE;
    HRESP_S = 2'b10;
    chk_rsp("s1_resp", 1'b1, 1'b1);
    tick();
    HRESP_S = 2'b00;

    // Saturation
    force dut.u_default_slave.err_count_q = 16'hFFFF;
    tick();
    release dut.u_default_slave.err_count_q;
    HADDR = 32'h0000_3000; HTRANS = NONSEQ;
    tick();
    HADDR = 32'h0; HTRANS = IDLE;
    chk_rsp("sat_err1", 1'b0, 1'b1);
    chk("sat_errcnt", {16'd0, err_count}, 32'hFFFF);

    // Reset during ERR1 aborts the error response
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk_rsp("rst_err1", 1'b1, 1'b0);
    chk("rst_err1_cnt", {16'd0, err_count}, 32'h0);
    chk("rst_err1_data", HRDATA, 32'h0);
    tick();
    chk_rsp("post_rst", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
